// File: rtl/lcd_text_reader.sv
// Read-side engine for an HD44780-class character LCD: single BF/address or data reads,
// plus a busy-poll mode that repeats BF reads until the controller reports ready.
module lcd_text_reader #(
    parameter int T_AS     = 2,
    parameter int T_EH     = 8,
    parameter int T_HOLD   = 2,
    parameter int MAX_POLL = 4
) (
    input  logic       LCDCLK,
    input  logic       PRESETn,
    input  logic       rd_req,
    input  logic       rd_rs,
    input  logic       rd_poll,
    output logic       rd_ready,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       busy_flag,
    output logic [6:0] addr_cnt,
    output logic       timeout,
    input  logic [7:0] LCD_DATA_IN,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN
);

    localparam int CNT_W = $clog2(T_AS + T_EH + T_HOLD + 1);
    localparam int PC_W  = $clog2(MAX_POLL + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_EN_HI,
        S_HOLD,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [PC_W-1:0]   poll_cnt_q;
    logic              poll_q;
    logic              phase_last;
    logic              repoll;
    logic              rd_ready_q;
    logic              rd_valid_q;
    logic [7:0]        rd_data_q;
    logic              busy_flag_q;
    logic [6:0]        addr_cnt_q;
    logic              timeout_q;
    logic              lcd_rs_q;
    logic              lcd_rw_q;
    logic              lcd_en_q;

    // One shared phase counter times SETUP, EN_HI and HOLD; it restarts at every phase change.
    always_comb begin
        phase_last = 1'b0;
        case (state_q)
            S_SETUP: phase_last = (cnt_q == CNT_W'(T_AS - 1));
            S_EN_HI: phase_last = (cnt_q == CNT_W'(T_EH - 1));
            S_HOLD:  phase_last = (cnt_q == CNT_W'(T_HOLD - 1));
            default: phase_last = 1'b0;
        endcase
        cnt_d  = phase_last ? '0 : cnt_q + CNT_W'(1);
        repoll = poll_q && rd_data_q[7] && (poll_cnt_q < PC_W'(MAX_POLL - 1));
    end

    always_ff @(posedge LCDCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            poll_cnt_q  <= '0;
            poll_q      <= 1'b0;
            rd_ready_q  <= 1'b1;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            busy_flag_q <= 1'b0;
            addr_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            lcd_rs_q    <= 1'b0;
            lcd_rw_q    <= 1'b0;
            lcd_en_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rd_req) begin
                        lcd_rs_q   <= rd_rs;
                        lcd_rw_q   <= 1'b1;
                        rd_ready_q <= 1'b0;
                        poll_q     <= rd_poll && !rd_rs;
                        poll_cnt_q <= '0;
                        cnt_q      <= '0;
                        state_q    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    cnt_q <= cnt_d;
                    if (phase_last) begin
                        lcd_en_q <= 1'b1;
                        state_q  <= S_EN_HI;
                    end
                end
                S_EN_HI: begin
                    cnt_q <= cnt_d;
                    if (phase_last) begin
                        lcd_en_q  <= 1'b0;
                        rd_data_q <= LCD_DATA_IN;
                        state_q   <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    cnt_q <= cnt_d;
                    if (phase_last) begin
                        if (repoll) begin
                            poll_cnt_q <= poll_cnt_q + PC_W'(1);
                            state_q    <= S_SETUP;
                        end else begin
                            lcd_rw_q   <= 1'b0;
                            lcd_rs_q   <= 1'b0;
                            rd_valid_q <= 1'b1;
                            timeout_q  <= poll_q && rd_data_q[7];
                            // Data-register reads leave the last known address untouched.
                            if (!lcd_rs_q) begin
                                busy_flag_q <= rd_data_q[7];
                                addr_cnt_q  <= rd_data_q[6:0];
                            end else begin
                                busy_flag_q <= 1'b0;
                            end
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    rd_valid_q <= 1'b0;
                    rd_ready_q <= 1'b1;
                    state_q    <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_ready  = rd_ready_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign busy_flag = busy_flag_q;
    assign addr_cnt  = addr_cnt_q;
    assign timeout   = timeout_q;
    assign LCD_RS    = lcd_rs_q;
    assign LCD_RW    = lcd_rw_q;
    assign LCD_EN    = lcd_en_q;

endmodule

// File: tb/tb_lcd_text_reader.sv
// Scoreboard bench for lcd_text_reader: a transaction-level model predicts each read result,
// a negedge monitor compares every rd_valid against it and watches the LCD strobe timing.
module tb_lcd_text_reader;

    localparam int T_AS     = 2;
    localparam int T_EH     = 8;
    localparam int T_HOLD   = 2;
    localparam int MAX_POLL = 4;
    localparam int RD_CYC   = T_AS + T_EH + T_HOLD;

    logic       LCDCLK = 1'b0;
    logic       PRESETn = 1'b1;
    logic       rd_req = 1'b0;
    logic       rd_rs = 1'b0;
    logic       rd_poll = 1'b0;
    logic       rd_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       busy_flag;
    logic [6:0] addr_cnt;
    logic       timeout;
    logic [7:0] LCD_DATA_IN;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_EN;

    lcd_text_reader #(
        .T_AS(T_AS), .T_EH(T_EH), .T_HOLD(T_HOLD), .MAX_POLL(MAX_POLL)
    ) dut (
        .LCDCLK(LCDCLK), .PRESETn(PRESETn),
        .rd_req(rd_req), .rd_rs(rd_rs), .rd_poll(rd_poll),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
        .busy_flag(busy_flag), .addr_cnt(addr_cnt), .timeout(timeout),
        .LCD_DATA_IN(LCD_DATA_IN), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN)
    );

    always #5 LCDCLK = ~LCDCLK;

    typedef struct {
        logic [7:0] data;
        logic       busy;
        logic [6:0] addr;
        logic       tmo;
        int         lat;
        int         npulse;
    } exp_t;

    exp_t       sb_q[$];
    int         acc_q[$];
    logic [7:0] bus_b[MAX_POLL];
    logic [6:0] m_addr = '0;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         n_acc = 0;
    int         falls = 0;

    // The LCD answers the k-th EN pulse of a transaction with bus_b[k].
    assign LCD_DATA_IN = bus_b[(falls < MAX_POLL) ? falls : MAX_POLL - 1];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic rs, input logic poll, input logic [6:0] prev_addr);
        exp_t e;
        int   n;
        bit   found;
        n = 1;
        if (poll && !rs) begin
            found = 0;
            n = MAX_POLL;
            for (int i = 0; i < MAX_POLL; i++) begin
                if (!found && !bus_b[i][7]) begin
                    n = i + 1;
                    found = 1;
                end
            end
        end
        e.data   = bus_b[n - 1];
        e.tmo    = poll && !rs && e.data[7];
        e.busy   = rs ? 1'b0 : e.data[7];
        e.addr   = rs ? prev_addr : e.data[6:0];
        e.lat    = n * RD_CYC;
        e.npulse = n;
        return e;
    endfunction

    always @(posedge LCDCLK) begin
        cyc <= cyc + 1;
        if (PRESETn && rd_req && rd_ready) begin
            acc_q.push_back(cyc + 1);
            n_acc <= n_acc + 1;
        end
    end

    // Monitor: strobe protocol and scoreboard compare, sampled on the falling edge.
    initial begin
        exp_t e;
        int   seen_acc;
        int   en_w;
        int   lat;
        logic en_prev;
        logic vld_prev;
        logic rs_at_en;
        seen_acc = 0;
        en_w = 0;
        en_prev = 1'b0;
        vld_prev = 1'b0;
        rs_at_en = 1'b0;
        forever begin
            @(negedge LCDCLK);
            if (!PRESETn) begin
                falls = 0;
                en_w = 0;
                en_prev = 1'b0;
                vld_prev = 1'b0;
                seen_acc = n_acc;
                acc_q.delete();
            end else begin
                if (n_acc != seen_acc) begin
                    seen_acc = n_acc;
                    falls = 0;
                end
                if (LCD_EN) begin
                    if (!en_prev) rs_at_en = LCD_RS;
                    else chk("rs_stable_en", LCD_RS, rs_at_en);
                    chk("rw_during_en", LCD_RW, 1);
                    en_w++;
                end else if (en_prev) begin
                    chk("en_width", en_w, T_EH);
                    en_w = 0;
                    falls++;
                end
                en_prev = LCD_EN;
                if (rd_valid) begin
                    chk("valid_one_cycle", vld_prev, 0);
                    if (sb_q.size() == 0) begin
                        chk("unexpected_valid", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        lat = (acc_q.size() != 0) ? cyc - acc_q.pop_front() : -1;
                        chk("rd_data", rd_data, e.data);
                        chk("busy_flag", busy_flag, e.busy);
                        chk("addr_cnt", addr_cnt, e.addr);
                        chk("timeout", timeout, e.tmo);
                        chk("latency", lat, e.lat);
                        chk("en_pulses", falls, e.npulse);
                        chk("rw_at_valid", LCD_RW, 0);
                        chk("rs_at_valid", LCD_RS, 0);
                        chk("ready_at_valid", rd_ready, 0);
                    end
                end
                vld_prev = rd_valid;
            end
        end
    end

    task automatic set_bus(input logic [7:0] b0, b1, b2, b3);
        bus_b[0] = b0;
        bus_b[1] = b1;
        bus_b[2] = b2;
        bus_b[3] = b3;
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (!rd_ready && i < 300) begin
            @(negedge LCDCLK);
            i++;
        end
        chk("ready_return", rd_ready, 1);
    endtask

    task automatic issue(input logic rs, input logic poll, input logic [7:0] b0, b1, b2, b3,
                         input bit jam);
        exp_t e;
        int   start;
        int   i;
        @(negedge LCDCLK);
        set_bus(b0, b1, b2, b3);
        e = model(rs, poll, m_addr);
        m_addr = e.addr;
        sb_q.push_back(e);
        start = n_acc;
        rd_rs = rs;
        rd_poll = poll;
        rd_req = 1'b1;
        i = 0;
        while (n_acc == start && i < 50) begin
            @(negedge LCDCLK);
            i++;
        end
        chk("accepted", n_acc - start, 1);
        rd_req = 1'b0;
        // Requests raised while busy must be dropped, and late RS/poll changes must not leak in.
        if (jam) begin
            for (int k = 0; k < 6; k++) begin
                rd_req = 1'($urandom_range(0, 1));
                rd_rs = 1'($urandom_range(0, 1));
                rd_poll = 1'($urandom_range(0, 1));
                @(negedge LCDCLK);
            end
            rd_req = 1'b0;
        end
        wait_idle();
    endtask

    initial begin
        int         start;
        int         i;
        int         c1;
        int         c3;
        exp_t       e;
        logic [7:0] rb[MAX_POLL];
        bit         stick;

        set_bus(8'h00, 8'h00, 8'h00, 8'h00);
        #1 PRESETn = 1'b0;
        #2;
        chk("rst_ready", rd_ready, 1);
        chk("rst_valid", rd_valid, 0);
        chk("rst_en", LCD_EN, 0);
        chk("rst_rw", LCD_RW, 0);
        chk("rst_rs", LCD_RS, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_addr", addr_cnt, 0);
        chk("rst_timeout", timeout, 0);
        repeat (3) @(negedge LCDCLK);
        PRESETn = 1'b1;
        repeat (2) @(negedge LCDCLK);

        issue(1'b0, 1'b0, 8'h85, 8'h00, 8'h00, 8'h00, 1'b0);
        issue(1'b1, 1'b0, 8'h41, 8'h00, 8'h00, 8'h00, 1'b0);
        issue(1'b0, 1'b1, 8'h8A, 8'hC3, 8'h10, 8'h80, 1'b0);
        issue(1'b0, 1'b1, 8'h80, 8'h80, 8'h80, 8'h80, 1'b0);
        issue(1'b1, 1'b1, 8'hC3, 8'h00, 8'h00, 8'h00, 1'b1);
        issue(1'b0, 1'b1, 8'h7F, 8'h80, 8'h80, 8'h80, 1'b1);

        // Reset while EN is high: strobe and RW must fall immediately and no result may appear.
        @(negedge LCDCLK);
        set_bus(8'h85, 8'h85, 8'h85, 8'h85);
        rd_rs = 1'b0;
        rd_poll = 1'b0;
        rd_req = 1'b1;
        start = n_acc;
        i = 0;
        while (n_acc == start && i < 50) begin
            @(negedge LCDCLK);
            i++;
        end
        rd_req = 1'b0;
        i = 0;
        while (!LCD_EN && i < 50) begin
            @(negedge LCDCLK);
            i++;
        end
        chk("en_reached", LCD_EN, 1);
        repeat (2) @(negedge LCDCLK);
        #2 PRESETn = 1'b0;
        #1;
        chk("abort_en", LCD_EN, 0);
        chk("abort_rw", LCD_RW, 0);
        chk("abort_rs", LCD_RS, 0);
        chk("abort_ready", rd_ready, 1);
        chk("abort_valid", rd_valid, 0);
        chk("abort_addr", addr_cnt, 0);
        m_addr = '0;
        @(negedge LCDCLK);
        @(negedge LCDCLK);
        PRESETn = 1'b1;
        repeat (20) @(negedge LCDCLK);
        chk("post_abort_ready", rd_ready, 1);

        // Continuous request: back-to-back reads separated by a single idle cycle.
        @(negedge LCDCLK);
        set_bus(8'h5A, 8'h5A, 8'h5A, 8'h5A);
        for (int k = 0; k < 3; k++) begin
            e = model(1'b1, 1'b0, m_addr);
            m_addr = e.addr;
            sb_q.push_back(e);
        end
        rd_rs = 1'b1;
        rd_poll = 1'b0;
        rd_req = 1'b1;
        start = n_acc;
        c1 = 0;
        c3 = 0;
        i = 0;
        while (n_acc - start < 3 && i < 200) begin
            @(negedge LCDCLK);
            if (n_acc - start == 1 && c1 == 0) c1 = cyc;
            i++;
        end
        c3 = cyc;
        rd_req = 1'b0;
        chk("b2b_count", n_acc - start, 3);
        chk("b2b_spacing", c3 - c1, 2 * (RD_CYC + 2));
        wait_idle();

        for (int t = 0; t < 40; t++) begin
            stick = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < MAX_POLL; k++) begin
                rb[k] = 8'($urandom);
                rb[k][7] = stick ? 1'b1 : 1'($urandom_range(0, 2) != 0);
            end
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  rb[0], rb[1], rb[2], rb[3], 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge LCDCLK);
        end

        repeat (5) @(negedge LCDCLK);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
